// File: rtl/clkdiv_mon_pkg.sv
// clkdiv_mon_pkg: shared types and default sizing for the divided-clock monitor.
// The monitor state type and the default measurement constants live here so the
// top level and any harness that instantiates it agree on the same values.

package clkdiv_mon_pkg;

  // Default counter width for period/high-time measurement and result outputs.
  localparam int DEF_CNT_W      = 8;
  // Expected rising-to-rising period of the divided clock, in clkin cycles.
  localparam int DEF_EXP_PERIOD = 6;
  // Expected high-phase length of the divided clock, in clkin cycles.
  localparam int DEF_EXP_HIGH   = 3;
  // Consecutive good periods needed before locked asserts.
  localparam int DEF_LOCK_COUNT = 4;
  // clkin cycles without a rising edge before the clock is declared stuck.
  localparam int DEF_TIMEOUT    = 24;

  // Monitor state: hunting for a first edge, measuring, or locked.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  // Width needed to hold a count from 0 up to and including n.
  function automatic int count_bits(input int n);
    int w;
    w = $clog2(n + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/clkdiv_edge_detect.sv
// clkdiv_edge_detect: samples the divided clock as data in the clkin domain and
// produces registered one-cycle rise/fall strobes.
// Build option CLKDIV_MON_SYNC_EN inserts a 2-flop synchronizer in front of the
// sample flop for a divided clock that is not derived from clkin; without it the
// input is assumed to be generated synchronously from clkin.

module clkdiv_edge_detect
  import clkdiv_mon_pkg::*;
(
  input  logic clkin,
  input  logic reset,
  input  logic clkdiv_in,
  output logic rise,
  output logic fall
);

  logic clk_s;
  logic clk_d;
  logic sample_src;

`ifdef CLKDIV_MON_SYNC_EN
  logic sync1;
  logic sync2;

  // Two-stage synchronizer so a foreign-domain divided clock settles before use.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= clkdiv_in;
      sync2 <= sync1;
    end
  end

  assign sample_src = sync2;
`else
  assign sample_src = clkdiv_in;
`endif

  // Sample flop plus one-cycle history, the pair the edge compare looks at.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      clk_s <= 1'b0;
      clk_d <= 1'b0;
    end else begin
      clk_s <= sample_src;
      clk_d <= clk_s;
    end
  end

  // Registered edge strobes so the measurement logic sees clean single-cycle pulses.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= clk_s & ~clk_d;
      fall <= ~clk_s & clk_d;
    end
  end

endmodule

// File: rtl/clkdiv_monitor.sv
// clkdiv_monitor: measures the period and high time of a divided clock in clkin
// cycles, declares lock after a run of correct periods and raises sticky errors
// for wrong periods or a stalled clock.
// Build option CLKDIV_MON_SYNC_EN (handled in clkdiv_edge_detect) adds a 2-flop
// input synchronizer, moving every result two clkin cycles later.

module clkdiv_monitor
  import clkdiv_mon_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int EXP_HIGH   = DEF_EXP_HIGH,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             clkdiv_in,
  input  logic             err_clr,
  output logic             locked,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             err_period,
  output logic             err_stuck
);

  localparam int GW = count_bits(LOCK_COUNT);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LOCK_N  = GW'(LOCK_COUNT);
  localparam logic [GW-1:0]    GOOD_ONE = GW'(1);

  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cap;
  logic [GW-1:0]    good_cnt;
  mon_state_t       state;
  logic             stall_prev;
  logic             stall_hit;
  logic             stall_event;
  logic             measure_rise;
  logic             good_period;
  logic             lock_reached;

  clkdiv_edge_detect u_edge (
    .clkin     (clkin),
    .reset     (reset),
    .clkdiv_in (clkdiv_in),
    .rise      (rise),
    .fall      (fall)
  );

  // A stall is flagged once, on the first cycle the counter crosses the timeout;
  // a rise in that same cycle means the clock is alive, so it wins.
  assign stall_hit    = (cnt >= TMO);
  assign stall_event  = stall_hit & ~stall_prev & ~rise;
  assign measure_rise = rise & (state != SEARCH);
  assign good_period  = (cnt == EXP_P) && (hi_cap == EXP_H);
  assign lock_reached = (good_cnt >= (LOCK_N - GOOD_ONE));

  // Cycle counter since the last rise; on a rise it holds the full period length.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Capture the high-phase length when the divided clock falls.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      hi_cap <= '0;
    end else if (fall) begin
      hi_cap <= cnt;
    end
  end

  // Remember the previous timeout compare so each stall raises err_stuck once.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      stall_prev <= 1'b0;
    end else begin
      stall_prev <= stall_hit;
    end
  end

  // Lock state machine: a stall always drops back to SEARCH; otherwise each
  // rise after the first publishes a measurement and grades it.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state        <= SEARCH;
      good_cnt     <= '0;
      locked       <= 1'b0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (stall_event) begin
        state    <= SEARCH;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else if (rise) begin
        case (state)
          SEARCH: begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
          MEASURE, LOCKED: begin
            period_out   <= cnt;
            high_out     <= hi_cap;
            period_valid <= 1'b1;
            if (good_period) begin
              if (lock_reached) begin
                good_cnt <= LOCK_N;
                state    <= LOCKED;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_cnt + GOOD_ONE;
              end
            end else begin
              good_cnt <= '0;
              state    <= MEASURE;
              locked   <= 1'b0;
            end
          end
          default: begin
            state    <= SEARCH;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky error flags: err_clr clears them, but a fresh error in the same
  // cycle is kept, so the later set assignments deliberately override the clear.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      err_period <= 1'b0;
      err_stuck  <= 1'b0;
    end else begin
      if (err_clr) begin
        err_period <= 1'b0;
        err_stuck  <= 1'b0;
      end
      if (measure_rise && !good_period) begin
        err_period <= 1'b1;
      end
      if (stall_event) begin
        err_stuck <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// tb_clkdiv_monitor: directed bench for clkdiv_monitor. Each driven divided-clock
// period whose closing rise will be measured pushes its hand-computed result into
// a queue; a monitor pops and compares whenever period_valid pulses.

module tb_clkdiv_monitor;

  localparam int CNT_W = 8;
`ifdef CLKDIV_MON_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    int period;
    int high;
    int lck;
  } exp_t;

  logic             clkin = 1'b0;
  logic             reset;
  logic             clkdiv_in;
  logic             err_clr;
  logic             locked;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             period_valid;
  logic             err_period;
  logic             err_stuck;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_rise_cyc = 0;

  clkdiv_monitor dut (
    .clkin        (clkin),
    .reset        (reset),
    .clkdiv_in    (clkdiv_in),
    .err_clr      (err_clr),
    .locked       (locked),
    .period_out   (period_out),
    .high_out     (high_out),
    .period_valid (period_valid),
    .err_period   (err_period),
    .err_stuck    (err_stuck)
  );

  // 10 ns source clock
  always #5 clkin = ~clkin;

  // Edge counter used to measure input-to-valid latency
  always @(posedge clkin) cyc <= cyc + 1;

  // Single comparison point shared by the monitor and the directed checks
  task automatic checkOutput(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clkin cycle of stimulus, driven just after the rising edge
  task automatic tick(input logic v, input logic clr);
    @(posedge clkin);
    #1;
    if (v && !clkdiv_in) last_rise_cyc = cyc;
    clkdiv_in = v;
    err_clr   = clr;
  endtask

  // One divided-clock period; if push is set its result is expected once the
  // next rise closes it. clr_idx selects a tick that carries err_clr (-1: none).
  task automatic applyStimulus(input int hi, input int lo, input bit push,
                               input int exp_lck, input int clr_idx);
    exp_t e;
    if (push) begin
      e.period = hi + lo;
      e.high   = hi;
      e.lck    = exp_lck;
      exp_q.push_back(e);
    end
    for (int i = 0; i < hi + lo; i++) begin
      tick((i < hi) ? 1'b1 : 1'b0, (i == clr_idx) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " period_valid"}, int'(period_valid), 0);
    checkOutput({tag, " locked"},       int'(locked), 0);
    checkOutput({tag, " period_out"},   int'(period_out), 0);
    checkOutput({tag, " high_out"},     int'(high_out), 0);
    checkOutput({tag, " err_period"},   int'(err_period), 0);
    checkOutput({tag, " err_stuck"},    int'(err_stuck), 0);
  endtask

  // Monitor: every published measurement is matched against the queue head
  always @(negedge clkin) begin
    if (!reset && period_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_valid: got period %0d high %0d expected none",
                 period_out, high_out);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("period_out", int'(period_out), mon_e.period);
        checkOutput("high_out",   int'(high_out),   mon_e.high);
        checkOutput("locked_at_valid", int'(locked), mon_e.lck);
        checkOutput("valid_latency", cyc - last_rise_cyc, LAT);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    clkdiv_in = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clkin);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    // Nominal /6 clock: search rise, then lock on the 4th valid
    $display("[TB] nominal clock and lock");
    applyStimulus(3, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 1, -1);
    applyStimulus(3, 3, 1, 1, -1);
    checkOutput("locked_after_4", int'(locked), 1);
    checkOutput("err_period_nominal", int'(err_period), 0);
    checkOutput("err_stuck_nominal", int'(err_stuck), 0);

    // Stretched high phase from lock, then relock after 4 good periods
    $display("[TB] stretched high phase");
    applyStimulus(4, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 0, -1);
    checkOutput("err_period_stretch", int'(err_period), 1);
    checkOutput("locked_dropped", int'(locked), 0);
    applyStimulus(3, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 1, -1);

    // Stall: hold low until the timeout fires
    $display("[TB] stalled clock");
    applyStimulus(3, 10, 0, 0, -1);
    checkOutput("relocked", int'(locked), 1);
    checkOutput("err_period_sticky", int'(err_period), 1);
    checkOutput("err_stuck_before_timeout", int'(err_stuck), 0);
    applyStimulus(0, 20, 0, 0, -1);
    checkOutput("err_stuck_after_timeout", int'(err_stuck), 1);
    checkOutput("locked_after_stall", int'(locked), 0);

    // Resume: first rise is a search rise, no valid for it
    applyStimulus(3, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 0, 4);
    checkOutput("err_period_cleared", int'(err_period), 0);
    checkOutput("err_stuck_cleared", int'(err_stuck), 0);

    // Bad period detected in the same cycle as err_clr: error must survive
    $display("[TB] error set versus clear");
    applyStimulus(4, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 0, 2);
    checkOutput("err_period_set_beats_clr", int'(err_period), 1);
    applyStimulus(3, 2, 0, 0, -1);
    checkOutput("queue_drained_before_reset", exp_q.size(), 0);

    // Asynchronous reset between clkin edges
    $display("[TB] async reset mid-period");
    @(posedge clkin);
    #4;
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    clkdiv_in = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clkin);
    #1;
    reset = 1'b0;
    applyStimulus(3, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 0, -1);
    applyStimulus(3, 3, 1, 1, -1);
    applyStimulus(3, 3, 0, 0, -1);
    checkOutput("relock_after_reset", int'(locked), 1);
    checkOutput("err_period_after_reset", int'(err_period), 0);
    repeat (3) tick(1'b0, 1'b0);
    checkOutput("queue_drained_at_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
